// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the scanning channel-select mux.
//   state_t     : FSM encoding (IDLE, BLANK, PASS).
//   MODE_*      : values of the mode input.
//   clog2       : ceiling log2, used for constant width calculations.
// ---------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        PASS  = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Smallest r with (1 << r) >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_nx1.sv
// ---------------------------------------------------------------------------
// mux_nx1
// Purely combinational NUM_CH:1 selector. The parent registers the result.
// Ports:
//   a    in  NUM_CH  channel inputs
//   sel  in  SEL_W   channel index
//   y    out 1       a[sel], or 0 when sel >= NUM_CH
// ---------------------------------------------------------------------------
module mux_nx1 #(
    parameter int NUM_CH = 16,
    parameter int SEL_W  = 4
) (
    input  logic [NUM_CH-1:0] a,
    input  logic [SEL_W-1:0]  sel,
    output logic              y
);

    // A compare-per-channel loop keeps an out-of-range index (possible when
    // NUM_CH is not a power of two) from reading past the end of a.
    always_comb begin
        y = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                y = a[i];
            end
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// ---------------------------------------------------------------------------
// mux_scan_sel
// Registered NUM_CH:1 channel selector with manual and auto-scan modes.
// Every channel change blanks the output for BLANK cycles so that no runt
// pulse from the switch reaches the downstream pad or counter.
//
// Ports:
//   wb_clk_i  in   1        clock
//   wb_rst_i  in   1        synchronous active-high reset
//   en        in   1        block enable; 0 parks the FSM in IDLE
//   mode      in   1        0 = manual, 1 = auto-scan
//   sel_in    in   SEL_W    manual channel request
//   sel_load  in   1        strobe that requests sel_in (manual mode only)
//   dwell     in   DWELL_W  PASS cycles per channel in scan mode (0 acts as 1)
//   a         in   NUM_CH   channel inputs
//   y         out  1        registered selected channel, 0 when not valid
//   valid     out  1        y carries a settled channel
//   cur_sel   out  SEL_W    currently selected channel
//   wrap      out  1        one-cycle pulse when the scan wraps back to 0
// ---------------------------------------------------------------------------
module mux_scan_sel
    import mux_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 16,
    parameter int BLANK   = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               sel_load,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  a,
    output logic               y,
    output logic               valid,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap
);

    // The BLANK parameter shadows the imported state name, so the state
    // literals are always written package-qualified in this module.
    localparam int                   BLANK_W    = clog2(BLANK + 1);
    localparam logic [BLANK_W-1:0]   BLANK_INIT = BLANK_W'(BLANK - 1);
    localparam logic [SEL_W-1:0]     LAST_CH    = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]       NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);

    state_t               state;
    state_t               state_next;
    logic [SEL_W-1:0]     cur_sel_next;
    logic [BLANK_W-1:0]   blank_cnt;
    logic [BLANK_W-1:0]   blank_cnt_next;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [DWELL_W-1:0]   dwell_cnt_next;
    logic [DWELL_W-1:0]   dwell_limit;
    logic                 wrap_next;
    logic                 mode_q;
    logic                 mode_changed;
    logic                 sel_legal;
    logic                 manual_req;
    logic                 manual_switch;
    logic                 mux_y;

    mux_nx1 #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_mux (
        .a   (a),
        .sel (cur_sel),
        .y   (mux_y)
    );

    // Request decode. A manual request is only legal for an existing
    // channel; it causes a switch (and a blank) only when it actually names
    // a different channel. dwell = 0 is folded onto dwell = 1.
    always_comb begin
        sel_legal     = ({1'b0, sel_in} < NUM_CH_EXT);
        manual_req    = (mode == MODE_MANUAL) && sel_load && sel_legal;
        manual_switch = manual_req && (sel_in != cur_sel);
        mode_changed  = (mode != mode_q);
        dwell_limit   = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));
    end

    // Next-state logic. Priority: enable low parks the FSM (and beats a
    // coincident scan advance), then anything that forces a fresh blank
    // (leaving IDLE, a manual switch, a mode change), then the normal
    // BLANK countdown and PASS dwell counting.
    always_comb begin
        state_next     = state;
        cur_sel_next   = cur_sel;
        blank_cnt_next = blank_cnt;
        dwell_cnt_next = dwell_cnt;
        wrap_next      = 1'b0;

        if (!en) begin
            state_next = mux_pkg::IDLE;
            if (manual_req) begin
                cur_sel_next = sel_in;
            end
        end else if ((state == mux_pkg::IDLE) || manual_switch || mode_changed) begin
            state_next     = mux_pkg::BLANK;
            blank_cnt_next = BLANK_INIT;
            if (manual_switch) begin
                cur_sel_next = sel_in;
            end
            if (mode_changed) begin
                dwell_cnt_next = '0;
            end
        end else begin
            case (state)
                mux_pkg::BLANK: begin
                    if (blank_cnt == '0) begin
                        state_next     = mux_pkg::PASS;
                        dwell_cnt_next = '0;
                    end else begin
                        blank_cnt_next = blank_cnt - BLANK_W'(1);
                    end
                end
                mux_pkg::PASS: begin
                    if (mode == MODE_SCAN) begin
                        if (dwell_cnt == dwell_limit) begin
                            state_next     = mux_pkg::BLANK;
                            blank_cnt_next = BLANK_INIT;
                            if (cur_sel == LAST_CH) begin
                                cur_sel_next = '0;
                                wrap_next    = 1'b1;
                            end else begin
                                cur_sel_next = cur_sel + SEL_W'(1);
                            end
                        end else begin
                            dwell_cnt_next = dwell_cnt + DWELL_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = mux_pkg::IDLE;
                end
            endcase
        end
    end

    // State, counters and the output register. y/valid are computed from
    // the current state, so they trail the FSM by one cycle: the first
    // settled sample appears the cycle after PASS is entered, and the last
    // one the cycle after PASS is left.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= mux_pkg::IDLE;
            cur_sel   <= '0;
            blank_cnt <= '0;
            dwell_cnt <= '0;
            mode_q    <= MODE_MANUAL;
            y         <= 1'b0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_next;
            cur_sel   <= cur_sel_next;
            blank_cnt <= blank_cnt_next;
            dwell_cnt <= dwell_cnt_next;
            mode_q    <= mode;
            y         <= (state == mux_pkg::PASS) ? mux_y : 1'b0;
            valid     <= (state == mux_pkg::PASS);
            wrap      <= wrap_next;
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_sel
// Self-checking bench for mux_scan_sel (NUM_CH=16, BLANK=2).
// A vector table covers reset and manual selection; hand-written loops cover
// the multi-cycle scan, dwell=0, enable drop and re-enable sequences.
// ---------------------------------------------------------------------------
module tb_mux_scan_sel;

    localparam int NUM_CH    = 16;
    localparam int SEL_W     = 4;
    localparam int DWELL_W   = 16;
    localparam int BLANK_CYC = 2;
    localparam int NUM_VEC   = 24;

    logic               clk      = 1'b0;
    logic               rst      = 1'b0;
    logic               en       = 1'b0;
    logic               mode     = 1'b0;
    logic               sel_load = 1'b0;
    logic [SEL_W-1:0]   sel_in   = '0;
    logic [DWELL_W-1:0] dwell    = 16'd3;
    logic [NUM_CH-1:0]  a        = '0;
    logic               y;
    logic               valid;
    logic [SEL_W-1:0]   cur_sel;
    logic               wrap;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wraps  = 0;

    typedef struct packed {
        logic              rst;
        logic              en;
        logic              mode;
        logic              ld;
        logic [SEL_W-1:0]  sel;
        logic [NUM_CH-1:0] av;
        logic              ey;
        logic              ev;
        logic [SEL_W-1:0]  ecs;
        logic              ew;
    } vec_t;

    vec_t vecs [NUM_VEC];

    always #5 clk = ~clk;

    mux_scan_sel #(
        .NUM_CH  (NUM_CH),
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W),
        .BLANK   (BLANK_CYC)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .en       (en),
        .mode     (mode),
        .sel_in   (sel_in),
        .sel_load (sel_load),
        .dwell    (dwell),
        .a        (a),
        .y        (y),
        .valid    (valid),
        .cur_sel  (cur_sel),
        .wrap     (wrap)
    );

    // Drive inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic m,
                                 input logic l, input logic [SEL_W-1:0] s,
                                 input logic [NUM_CH-1:0] av);
        rst      = r;
        en       = e;
        mode     = m;
        sel_load = l;
        sel_in   = s;
        a        = av;
        @(posedge clk);
        #1;
        if (wrap) n_wraps++;
    endtask

    task automatic checkValue(input string name, input int idx, input string field,
                              input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s[%0d] %s: got %0d, expected %0d", name, idx, field, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int idx, input logic ey,
                               input logic ev, input logic [SEL_W-1:0] ecs, input logic ew);
        checkValue(name, idx, "y", int'(y), int'(ey));
        checkValue(name, idx, "valid", int'(valid), int'(ev));
        checkValue(name, idx, "cur_sel", int'(cur_sel), int'(ecs));
        checkValue(name, idx, "wrap", int'(wrap), int'(ew));
    endtask

    initial begin
        int ch;
        int prev;
        int off;
        int limit;

        //          rst   en    mode  ld    sel   a         ey    ev    ecs   ew
        vecs[0]  = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0004, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[1]  = {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0004, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[2]  = {1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0004, 1'b0, 1'b0, 4'd2, 1'b0};
        vecs[3]  = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0004, 1'b0, 1'b0, 4'd2, 1'b0};
        vecs[4]  = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0004, 1'b0, 1'b0, 4'd2, 1'b0};
        vecs[5]  = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0004, 1'b1, 1'b1, 4'd2, 1'b0};
        vecs[6]  = {1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0004, 1'b1, 1'b1, 4'd2, 1'b0};
        vecs[7]  = {1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 16'h0004, 1'b1, 1'b1, 4'd5, 1'b0};
        vecs[8]  = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0004, 1'b0, 1'b0, 4'd5, 1'b0};
        vecs[9]  = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0004, 1'b0, 1'b0, 4'd5, 1'b0};
        vecs[10] = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0004, 1'b0, 1'b1, 4'd5, 1'b0};
        vecs[11] = {1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 16'h0011, 1'b0, 1'b1, 4'd3, 1'b0};
        vecs[12] = {1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 16'h0011, 1'b0, 1'b0, 4'd4, 1'b0};
        vecs[13] = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0011, 1'b0, 1'b0, 4'd4, 1'b0};
        vecs[14] = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0011, 1'b0, 1'b0, 4'd4, 1'b0};
        vecs[15] = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0011, 1'b1, 1'b1, 4'd4, 1'b0};
        vecs[16] = {1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 16'h0011, 1'b1, 1'b1, 4'd7, 1'b0};
        vecs[17] = {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0011, 1'b0, 1'b0, 4'd7, 1'b0};
        vecs[18] = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0011, 1'b0, 1'b0, 4'd7, 1'b0};
        vecs[19] = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0011, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[20] = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0011, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[21] = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0011, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[22] = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0011, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[23] = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0011, 1'b1, 1'b1, 4'd0, 1'b0};

        $display("[TB] reset and manual-select vectors");
        for (int i = 0; i < NUM_VEC; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].ld,
                          vecs[i].sel, vecs[i].av);
            checkOutput("vec", i, vecs[i].ey, vecs[i].ev, vecs[i].ecs, vecs[i].ew);
        end

        // Manual PASS on ch0 -> scan, dwell=3. The mode change blanks like a
        // channel step, so each channel period is 5 edges: offset 0 shows the
        // new cur_sel with the last sample of the old channel, offsets 1-2
        // are blank, offsets 3-4 carry the new channel.
        $display("[TB] scan, dwell=3");
        n_wraps = 0;
        dwell   = 16'd3;
        for (int k = 0; k <= 17; k++) begin
            ch    = k % NUM_CH;
            prev  = (k == 0) ? 0 : (k - 1) % NUM_CH;
            limit = (k == 17) ? 1 : 5;
            for (int o = 0; o < limit; o++) begin
                applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'hAAAA);
                if (o == 0)
                    checkOutput("scan3", k * 5 + o, a[prev], 1'b1, SEL_W'(ch),
                                (k > 0) && (ch == 0));
                else if (o < 3)
                    checkOutput("scan3", k * 5 + o, 1'b0, 1'b0, SEL_W'(ch), 1'b0);
                else
                    checkOutput("scan3", k * 5 + o, a[ch], 1'b1, SEL_W'(ch), 1'b0);
            end
        end
        checkValue("wrap_count", 0, "pulses", n_wraps, 1);

        // dwell=0 acts as 1: one valid cycle per channel, period 1+BLANK.
        // Changed during BLANK so the next PASS entry starts from a clean count.
        $display("[TB] scan, dwell=0");
        dwell = 16'd0;
        for (int j = 1; j <= 15; j++) begin
            off = j % 3;
            ch  = 1 + j / 3;
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'hAAAA);
            if (off == 0)
                checkOutput("scan0", j, a[ch-1], 1'b1, SEL_W'(ch), 1'b0);
            else
                checkOutput("scan0", j, 1'b0, 1'b0, SEL_W'(ch), 1'b0);
        end

        // Back to dwell=3 from ch6, run into PASS on ch9.
        $display("[TB] scan to ch9, enable drop and re-enable");
        dwell = 16'd3;
        for (int j = 1; j <= 17; j++) begin
            off = j % 5;
            ch  = 6 + j / 5;
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'hAAAA);
            if (off == 0)
                checkOutput("scan9", j, a[ch-1], 1'b1, SEL_W'(ch), 1'b0);
            else if (off < 3)
                checkOutput("scan9", j, 1'b0, 1'b0, SEL_W'(ch), 1'b0);
            else
                checkOutput("scan9", j, a[ch], 1'b1, SEL_W'(ch), 1'b0);
        end

        // Drop enable in PASS on ch9: cur_sel holds, valid gone a cycle later.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'hAAAA);
        checkValue("en_drop", 0, "cur_sel", int'(cur_sel), 9);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'hAAAA);
        checkOutput("en_drop", 1, 1'b0, 1'b0, 4'd9, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'hAAAA);
        checkOutput("en_drop", 2, 1'b0, 1'b0, 4'd9, 1'b0);

        // Re-enable: blank, then a full 3-cycle dwell on ch9. Enable falls on
        // the edge that would advance to ch10, and must win.
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'hAAAA);
            if (j < 3)
                checkOutput("reen", j, 1'b0, 1'b0, 4'd9, 1'b0);
            else
                checkOutput("reen", j, a[9], 1'b1, 4'd9, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'hAAAA);
        checkOutput("en_wins", 0, a[9], 1'b1, 4'd9, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'hAAAA);
        checkOutput("en_wins", 1, 1'b0, 1'b0, 4'd9, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'hAAAA);
        checkOutput("en_wins", 2, 1'b0, 1'b0, 4'd9, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
